cla_pipe_addsub: RTL and testbench
==================================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor that succeeds the fixed 32-bit combinational `cla_32`. It splits a WIDTH-bit add/subtract into STAGES skewed pipeline segments built from BLOCK-bit lookahead groups. It exposes a valid/ready stream on both sides, so the datapath and ALU can run it at a higher clock with backpressure. It also produces carry, signed-overflow and zero flags, with optional signed saturation.

## Interface
- `WIDTH`, 32: operand width; must be a multiple of `STAGES*BLOCK`.
- `BLOCK`, 4: bits per lookahead group.
- `STAGES`, 2: pipeline segments; latency in cycles; 1..WIDTH/BLOCK.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `a`, `b`  in  WIDTH  operands.
- `c_in`  in  1  carry in (add) / borrow in (sub).
- `sub`  in  1  0: add, 1: subtract.
- `sat`  in  1  request signed saturation; ignored unless the macro is defined.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts the result.
- `s`  out  WIDTH  sum/difference.
- `c_out`  out  1  carry out; for sub, 1 = no borrow.
- `ovf`  out  1  signed overflow.
- `zero`  out  1  `s == 0`, evaluated after saturation.

## Operation
- Add: `{c_out,s} = a + b + c_in`.
- Sub: `{c_out,s} = a + ~b + ~c_in`, i.e. `a - b - c_in`.
- `ovf` = carry into the MSB XOR carry out of the MSB, computed on the unsaturated result.
- Segment k (k = 0..STAGES-1) covers bits [k*W/S +: W/S].
  - It is built from BLOCK-bit groups with group P/G and a second-level lookahead across the groups.
  - Its carry-in is the registered carry of segment k-1.
  - Segment 0 takes `c_in` XOR `sub` as its carry-in.
- Skew: operand bits of segment k travel through k delay registers before being added; completed low result bits travel through STAGES-1-k registers. All bits of a beat therefore emerge together.
- Pipeline control is a single global advance: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - While `adv = 0`, every stage register, including the valid bits, holds.
  - Bubbles are not collapsed.
- A beat is accepted on `in_valid && in_ready`. A result transfers on `out_valid && out_ready`.
- `sub` and `sat` are carried with the beat through every stage.

## Timing
- Latency is exactly STAGES cycles from acceptance to `out_valid` when not stalled. Throughput is 1 beat/cycle.
- With STAGES=1 the single register stage sits at the output; the result appears the cycle after acceptance.
- Reset: all valid bits are 0; `out_valid=0`, `s=0`, `c_out=0`, `ovf=0`, `zero=0`. `in_ready` = 1 during and after reset (because `out_valid=0`).
- Reset asserted mid-operation discards all in-flight beats immediately (asynchronously). No partial result is ever presented.
- Simultaneous output transfer and input acceptance in the same cycle is legal and sustains full rate.
- While `out_valid && !out_ready`, `s`/`c_out`/`ovf`/`zero` are held stable.
- Wrap-around: the carry out of the MSB is never fed back; results are modulo 2^WIDTH unless saturated.

## Configuration
- `CLA_PIPE_SAT_EN` defined: when the beat's `sat=1` and `ovf=1`, `s` is clamped to the signed maximum (`0111…1`) if the MSB of `a` is 0, or to the signed minimum (`1000…0`) if it is 1. `c_out` and `ovf` still report the raw result.
- `CLA_PIPE_SAT_EN` undefined: the `sat` port exists but is ignored; no clamp logic is synthesised.

## Structure
- Package `cla_pkg`:
  - localparam helpers `SEG_W = WIDTH/STAGES` and `GROUPS = SEG_W/BLOCK`.
  - function `sat_value(msb, width)`.
  - an elaboration check that WIDTH is divisible by STAGES*BLOCK.
- One sub-module, `cla_block`: a combinational BLOCK-bit lookahead group with inputs `a`, `b`, `cin` and outputs `s`, group `P`, group `G`. It is instantiated GROUPS×STAGES times.
- The top level owns the skew registers, the per-stage carry registers, the valid chain and the flag logic.

## Test plan
- WIDTH=32, STAGES=2: add `0x7FFFFFFF + 0x80000001`, c_in=0 -> after 2 cycles `s=0`, `c_out=1`, `ovf=0`, `zero=1`.
- Back-to-back beats `1021201+1457454` and `6553500+1111145` -> `s=2478655` then `s=7664645` on consecutive cycles, no gaps.
- sub=1: `65535656 - 11112441`, c_in=0 -> `s=54423215`, `c_out=1`. Then `1 - 2` -> `s=0xFFFFFFFF`, `c_out=0`, `ovf=0`.
- Overflow: `0x7FFFFFFF + 1` -> `s=0x80000000`, `ovf=1`. With `CLA_PIPE_SAT_EN` and `sat=1` -> `s=0x7FFFFFFF`, `ovf=1`.
- Backpressure: hold `out_ready=0` for 5 cycles with `in_valid=1` -> `in_ready=0` and outputs stable throughout; on release, the results drain in order with no loss or duplication.
- Reset mid-flight: assert `rst_n=0` with 2 beats in the pipe -> `out_valid=0` immediately. After release, the first new beat returns its correct sum after STAGES cycles. Repeat the same checks for STAGES=1 and for STAGES=4, BLOCK=8.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder/subtractor.
// Contents: segment/group width helpers, a configuration legality check,
// and the signed saturation constant generator used when CLA_PIPE_SAT_EN
// is defined.
package cla_pkg;

  // Widest operand the saturation helper can produce.
  localparam int unsigned MAX_W = 256;

  // Bits handled by one pipeline segment.
  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Lookahead groups inside one segment.
  function automatic int unsigned group_count(input int unsigned seg_w,
                                              input int unsigned block);
    return (block == 0) ? 0 : seg_w / block;
  endfunction

  // Legal when WIDTH splits evenly into STAGES*BLOCK and STAGES fits.
  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned block,
                                input int unsigned stages);
    bit ok;
    ok = 1'b1;
    if (block == 0 || stages == 0 || width == 0) begin
      ok = 1'b0;
    end else begin
      if ((width % (stages * block)) != 0) ok = 1'b0;
      if (stages > (width / block)) ok = 1'b0;
    end
    return ok;
  endfunction

  // Signed max (msb=0 -> 0111..1) or signed min (msb=1 -> 1000..0).
  function automatic logic [MAX_W-1:0] sat_value(input logic msb,
                                                 input int unsigned width);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) v[i] = (i == width - 1) ? msb : ~msb;
    end
    return v;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead group.
// Ports: a, b  - group operand bits (b already conditioned for subtract)
//        cin   - carry into the group
//        s     - group sum bits
//        P, G  - group propagate / generate for the next lookahead level
module cla_block
  import cla_pkg::*;
#(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             P,
  output logic             G
);

  logic [BLOCK-1:0] bp;
  logic [BLOCK-1:0] bg;
  logic [BLOCK-1:0] c;

  assign bp = a ^ b;
  assign bg = a & b;

  // Bit carries inside the group plus the group generate term.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 1; i < BLOCK; i++) begin
      c[i] = bg[i-1] | (bp[i-1] & c[i-1]);
    end
    G = 1'b0;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      G = bg[i] | (bp[i] & G);
    end
  end

  assign P = &bp;
  assign s = bp ^ c;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined, skewed carry-lookahead adder/subtractor with valid/ready
// streaming on both sides and carry / signed-overflow / zero flags.
// Optional feature macro: CLA_PIPE_SAT_EN (signed saturation on sat=1).
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready  - operand beat handshake
//        a, b, c_in, sub, sat - operands, carry/borrow in, op select, clamp
//        out_valid/out_ready - result beat handshake
//        s, c_out, ovf, zero - result and flags (registered)
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG_W  = seg_width(WIDTH, STAGES);
  localparam int unsigned GROUPS = group_count(SEG_W, BLOCK);

  if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_err
    $error("cla_pipe_addsub: WIDTH must be a multiple of STAGES*BLOCK, STAGES in 1..WIDTH/BLOCK");
  end

  // Single global advance: the whole pipe moves or the whole pipe holds.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO_W = k * SEG_W;   // result bits already done
    localparam int unsigned HI_W = WIDTH - LO_W; // operand bits still pending

    logic [HI_W-1:0]       op_a;
    logic [HI_W-1:0]       op_b;
    logic                  cin;
    logic                  beat_v;
    logic                  beat_sub;
    logic                  beat_sat;
    logic [SEG_W-1:0]      seg_b;
    logic [SEG_W-1:0]      seg_s;
    logic                  seg_c;
    logic [GROUPS-1:0]     gp;
    logic [GROUPS-1:0]     gg;
    logic [GROUPS:0]       gc;
    logic [LO_W+SEG_W-1:0] done;

    // Stage 0 takes the port beat; later stages take the previous register.
    if (k == 0) begin : g_src
      assign op_a     = a;
      assign op_b     = b;
      assign cin      = c_in ^ sub;
      assign beat_v   = in_valid;
      assign beat_sub = sub;
      assign beat_sat = sat;
      assign done     = seg_s;
    end else begin : g_src
      assign op_a     = g_stg[k-1].g_pipe.a_q;
      assign op_b     = g_stg[k-1].g_pipe.b_q;
      assign cin      = g_stg[k-1].g_pipe.c_q;
      assign beat_v   = g_stg[k-1].g_pipe.v_q;
      assign beat_sub = g_stg[k-1].g_pipe.sub_q;
      assign beat_sat = g_stg[k-1].g_pipe.sat_q;
      assign done     = {seg_s, g_stg[k-1].g_pipe.done_q};
    end

    // Subtract is a + ~b + ~c_in; the ~c_in part is folded into stage 0 cin.
    assign seg_b = op_b[SEG_W-1:0] ^ {SEG_W{beat_sub}};

    for (genvar j = 0; j < GROUPS; j++) begin : g_grp
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a   (op_a[j*BLOCK +: BLOCK]),
        .b   (seg_b[j*BLOCK +: BLOCK]),
        .cin (gc[j]),
        .s   (seg_s[j*BLOCK +: BLOCK]),
        .P   (gp[j]),
        .G   (gg[j])
      );
    end

    // Second-level lookahead across the groups of this segment.
    always_comb begin
      gc    = '0;
      gc[0] = cin;
      for (int unsigned j = 0; j < GROUPS; j++) begin
        gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
    end
    assign seg_c = gc[GROUPS];

    if (k < STAGES - 1) begin : g_pipe
      logic [HI_W-SEG_W-1:0] a_q;
      logic [HI_W-SEG_W-1:0] b_q;
      logic [LO_W+SEG_W-1:0] done_q;
      logic                  c_q;
      logic                  v_q;
      logic                  sub_q;
      logic                  sat_q;

      // Pending operand bits move up one stage; finished bits ride along.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q    <= '0;
          b_q    <= '0;
          done_q <= '0;
          c_q    <= 1'b0;
          v_q    <= 1'b0;
          sub_q  <= 1'b0;
          sat_q  <= 1'b0;
        end else if (adv) begin
          a_q    <= op_a[HI_W-1:SEG_W];
          b_q    <= op_b[HI_W-1:SEG_W];
          done_q <= done;
          c_q    <= seg_c;
          v_q    <= beat_v;
          sub_q  <= beat_sub;
          sat_q  <= beat_sat;
        end
      end
    end else begin : g_out
      logic             msb_cin;
      logic             raw_ovf;
      logic [WIDTH-1:0] res_c;

      // Carry into the MSB recovered from the MSB sum bit.
      assign msb_cin = seg_s[SEG_W-1] ^ op_a[SEG_W-1] ^ seg_b[SEG_W-1];
      assign raw_ovf = msb_cin ^ seg_c;

`ifdef CLA_PIPE_SAT_EN
      // Clamp direction follows the sign of a; flags still report raw result.
      assign res_c = (beat_sat && raw_ovf) ?
                     WIDTH'(sat_value(op_a[SEG_W-1], WIDTH)) : done;
`else
      logic unused_sat;
      assign unused_sat = beat_sat;
      assign res_c      = done;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          s         <= '0;
          c_out     <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (adv) begin
          out_valid <= beat_v;
          s         <= res_c;
          c_out     <= seg_c;
          ovf       <= raw_ovf;
          zero      <= (res_c == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub: three instances (STAGES=2/BLOCK=4,
// STAGES=1/BLOCK=4, STAGES=4/BLOCK=8) share one stimulus stream.
module tb_cla_pipe_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic        sub;
  logic        sat;
  logic        out_ready;

  logic        in_ready_s2, out_valid_s2, c_out_s2, ovf_s2, zero_s2;
  logic [31:0] s_s2;
  logic        in_ready_s1, out_valid_s1, c_out_s1, ovf_s1, zero_s1;
  logic [31:0] s_s1;
  logic        in_ready_s4, out_valid_s4, c_out_s4, ovf_s4, zero_s4;
  logic [31:0] s_s4;

  int checks;
  int failures;

`ifdef CLA_PIPE_SAT_EN
  localparam logic [31:0] EXP_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG_SAT = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_POS_SAT = 32'h8000_0000;
  localparam logic [31:0] EXP_NEG_SAT = 32'h7FFF_FFFF;
`endif

  cla_pipe_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s2),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .sat(sat),
    .out_valid(out_valid_s2), .out_ready(out_ready),
    .s(s_s2), .c_out(c_out_s2), .ovf(ovf_s2), .zero(zero_s2)
  );

  cla_pipe_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .sat(sat),
    .out_valid(out_valid_s1), .out_ready(out_ready),
    .s(s_s1), .c_out(c_out_s1), .ovf(ovf_s1), .zero(zero_s1)
  );

  cla_pipe_addsub #(.WIDTH(32), .BLOCK(8), .STAGES(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s4),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .sat(sat),
    .out_valid(out_valid_s4), .out_ready(out_ready),
    .s(s_s4), .c_out(c_out_s4), .ovf(ovf_s4), .zero(zero_s4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat; each instance is checked at its own latency.
  task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic tc, input logic tsub, input logic tsat,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input logic ez);
    a = x; b = y; c_in = tc; sub = tsub; sat = tsat; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_s1_valid"}, 32'(out_valid_s1), 32'd1);
    chk({tag, "_s1_s"},     s_s1,              es);
    chk({tag, "_s1_cout"},  32'(c_out_s1),     32'(ec));
    chk({tag, "_s1_ovf"},   32'(ovf_s1),       32'(eo));
    chk({tag, "_s1_zero"},  32'(zero_s1),      32'(ez));
    chk({tag, "_s2_early"}, 32'(out_valid_s2), 32'd0);
    tick();
    chk({tag, "_s2_valid"}, 32'(out_valid_s2), 32'd1);
    chk({tag, "_s2_s"},     s_s2,              es);
    chk({tag, "_s2_cout"},  32'(c_out_s2),     32'(ec));
    chk({tag, "_s2_ovf"},   32'(ovf_s2),       32'(eo));
    chk({tag, "_s2_zero"},  32'(zero_s2),      32'(ez));
    tick();
    chk({tag, "_s4_early"}, 32'(out_valid_s4), 32'd0);
    tick();
    chk({tag, "_s4_valid"}, 32'(out_valid_s4), 32'd1);
    chk({tag, "_s4_s"},     s_s4,              es);
    chk({tag, "_s4_cout"},  32'(c_out_s4),     32'(ec));
    chk({tag, "_s4_ovf"},   32'(ovf_s4),       32'(eo));
    chk({tag, "_s4_zero"},  32'(zero_s4),      32'(ez));
    chk({tag, "_s2_drain"}, 32'(out_valid_s2), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    c_in = 1'b0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;

    // Reset state
    tick(); tick(); tick();
    chk("rst_out_valid", 32'(out_valid_s2), 32'd0);
    chk("rst_s",         s_s2,              32'd0);
    chk("rst_cout",      32'(c_out_s2),     32'd0);
    chk("rst_ovf",       32'(ovf_s2),       32'd0);
    chk("rst_zero",      32'(zero_s2),      32'd0);
    chk("rst_in_ready",  32'(in_ready_s2),  32'd1);
    chk("rst_s1_valid",  32'(out_valid_s1), 32'd0);
    chk("rst_s4_valid",  32'(out_valid_s4), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed single beats
    single("add_zero", 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, 1'b0,
           32'h0000_0000, 1'b1, 1'b0, 1'b1);
    single("sub_big", 32'd65535656, 32'd11112441, 1'b0, 1'b1, 1'b0,
           32'd54423215, 1'b1, 1'b0, 1'b0);
    single("sub_neg", 32'd1, 32'd2, 1'b0, 1'b1, 1'b0,
           32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    single("sub_borrow", 32'd10, 32'd3, 1'b1, 1'b1, 1'b0,
           32'd6, 1'b1, 1'b0, 1'b0);
    single("add_cin_wrap", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0,
           32'h0000_0000, 1'b1, 1'b0, 1'b1);
    single("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0,
           32'h8000_0000, 1'b0, 1'b1, 1'b0);
    single("sat_pos", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1,
           EXP_POS_SAT, 1'b0, 1'b1, 1'b0);
    single("sat_neg", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1,
           EXP_NEG_SAT, 1'b1, 1'b1, 1'b0);

    // Back-to-back beats, no gap
    a = 32'd1021201; b = 32'd1457454; c_in = 1'b0; sub = 1'b0; sat = 1'b0;
    in_valid = 1'b1;
    tick();
    a = 32'd6553500; b = 32'd1111145;
    tick();
    in_valid = 1'b0;
    chk("b2b_first_valid", 32'(out_valid_s2), 32'd1);
    chk("b2b_first_s",     s_s2,              32'd2478655);
    tick();
    chk("b2b_second_valid", 32'(out_valid_s2), 32'd1);
    chk("b2b_second_s",     s_s2,              32'd7664645);
    tick();
    chk("b2b_idle", 32'(out_valid_s2), 32'd0);
    tick(); tick(); tick();

    // Backpressure: output stalls for 5 cycles, then drains in order
    a = 32'd100; b = 32'd1; in_valid = 1'b1;
    tick();
    a = 32'd200; b = 32'd2;
    tick();
    chk("bp_first_valid", 32'(out_valid_s2), 32'd1);
    chk("bp_first_s",     s_s2,              32'd101);
    out_ready = 1'b0; a = 32'd300; b = 32'd3;
    #1;
    chk("bp_in_ready_low", 32'(in_ready_s2), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_valid",    32'(out_valid_s2), 32'd1);
      chk("bp_stall_s",        s_s2,              32'd101);
      chk("bp_stall_in_ready", 32'(in_ready_s2),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_drain1_valid", 32'(out_valid_s2), 32'd1);
    chk("bp_drain1_s",     s_s2,              32'd202);
    tick();
    chk("bp_drain2_valid", 32'(out_valid_s2), 32'd1);
    chk("bp_drain2_s",     s_s2,              32'd303);
    tick();
    chk("bp_drain_done", 32'(out_valid_s2), 32'd0);

    // Reset with two beats in flight
    a = 32'd5; b = 32'd6; in_valid = 1'b1;
    tick();
    a = 32'd7; b = 32'd8;
    tick();
    in_valid = 1'b0;
    chk("mid_valid", 32'(out_valid_s2), 32'd1);
    chk("mid_s",     s_s2,              32'd11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(out_valid_s2), 32'd0);
    chk("mid_rst_s",        s_s2,              32'd0);
    chk("mid_rst_s1_valid", 32'(out_valid_s1), 32'd0);
    chk("mid_rst_s4_valid", 32'(out_valid_s4), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_s2),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    single("post_rst", 32'd1234, 32'd4321, 1'b0, 1'b0, 1'b0,
           32'd5555, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
